// File: rtl/mod_arith_arbiter.sv
// -----------------------------------------------------------------------------
// mod_arith_arbiter
//
// Round-robin arbiter/sequencer sharing one modular-arithmetic engine among
// NUM_REQ requesters. One operation is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//
// Handshake rules:
//   Requester side: req_ready is a one-hot, single-cycle accept. Operands are
//   captured at the clock edge where req_valid[i] & req_ready[i] is high.
//   A requester may drop req_valid at any time before it is granted.
//   Engine side: eng_start is a single-cycle pulse. eng_done/eng_error are
//   only honoured in WAIT. Error wins over done in the same cycle.
//   Response side: rsp_valid is a one-hot, single-cycle strobe to the granted
//   requester. rsp_result/rsp_error hold their values until the next RESP.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            per-requester request handshake
//   req_a/req_b/req_modulus        packed operands, slice [i*WIDTH +: WIDTH]
//   req_op                         packed opcodes, slice [i*3 +: 3]
//   rsp_valid/rsp_result/rsp_error response strobe and shared result bus
//   eng_start/eng_a/eng_b/eng_modulus/eng_operation   engine command
//   eng_result/eng_done/eng_busy/eng_error            engine status
//   grant_id                       current/last granted requester
//   state_dbg                      FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Configuration:
//   MODARB_TIMEOUT_EN  when defined, a 16-bit watchdog ends WAIT after
//                      TIMEOUT_CYCLES cycles with rsp_error = 1, rsp_result = 0.
// -----------------------------------------------------------------------------
module mod_arith_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int WIDTH          = 256,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*WIDTH-1:0]   req_modulus,
    input  logic [NUM_REQ*3-1:0]       req_op,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       rsp_error,
    output logic                       eng_start,
    output logic [WIDTH-1:0]           eng_a,
    output logic [WIDTH-1:0]           eng_b,
    output logic [WIDTH-1:0]           eng_modulus,
    output logic [2:0]                 eng_operation,
    input  logic [WIDTH-1:0]           eng_result,
    input  logic                       eng_done,
    input  logic                       eng_busy,
    input  logic                       eng_error,
    output logic [IW-1:0]              grant_id,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant_sel;
    logic            grant_found;
    logic            grant_take;
    logic [IW:0]     scan_idx;      // one spare bit so rr_ptr + offset never wraps
    logic            wait_exit;
    logic            wait_err;
    logic [WIDTH-1:0] wait_res;

`ifdef MODARB_TIMEOUT_EN
    logic [15:0]     wd_cnt;
    logic            wd_expired;
    assign wd_expired = (wd_cnt == 16'(TIMEOUT_CYCLES));
`endif

    // Cyclic scan starting at rr_ptr: first pending requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan_idx >= (IW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_sel   = scan_idx[IW-1:0];
            end
        end
    end

    assign grant_take = (state == S_IDLE) && grant_found && !eng_busy;

    // Gated by rst_n so the accept pulse is held low while reset is asserted,
    // even though the FSM already sits in IDLE.
    assign req_ready = (grant_take && rst_n) ? (ONE_HOT_0 << grant_sel) : '0;
    assign eng_start = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP) ? (ONE_HOT_0 << grant_id) : '0;
    assign state_dbg = state;

    // Next state plus the WAIT completion decision (error beats done).
    always_comb begin
        state_nxt = state;
        wait_exit = 1'b0;
        wait_err  = 1'b0;
        wait_res  = '0;
        case (state)
            S_IDLE: begin
                if (grant_take) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_error) begin
                    wait_exit = 1'b1;
                    wait_err  = 1'b1;
                end else if (eng_done) begin
                    wait_exit = 1'b1;
                    wait_res  = eng_result;
`ifdef MODARB_TIMEOUT_EN
                end else if (wd_expired) begin
                    wait_exit = 1'b1;
                    wait_err  = 1'b1;
`endif
                end
                if (wait_exit) state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping and operand capture on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            grant_id      <= '0;
            eng_a         <= '0;
            eng_b         <= '0;
            eng_modulus   <= '0;
            eng_operation <= '0;
        end else if (grant_take) begin
            grant_id      <= grant_sel;
            rr_ptr        <= (grant_sel == IW'(NUM_REQ-1)) ? '0 : grant_sel + IW'(1);
            eng_a         <= req_a[grant_sel*WIDTH +: WIDTH];
            eng_b         <= req_b[grant_sel*WIDTH +: WIDTH];
            eng_modulus   <= req_modulus[grant_sel*WIDTH +: WIDTH];
            eng_operation <= req_op[grant_sel*3 +: 3];
        end
    end

    // Response registers only change when WAIT completes, so they hold
    // through RESP and until the next operation finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else if (wait_exit) begin
            rsp_result <= wait_res;
            rsp_error  <= wait_err;
        end
    end

`ifdef MODARB_TIMEOUT_EN
    // Loaded with 1 while in ISSUE so the first WAIT cycle reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= 16'd1;
        end else if (state == S_WAIT && wd_cnt != 16'hFFFF) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mod_arith_arbiter.sv
module tb_mod_arith_arbiter;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 32;
    localparam int IW      = 2;
    localparam int EW      = NUM_REQ + 1 + WIDTH;   // {onehot, error, result}
    localparam int QW      = 3 + 3 * WIDTH;          // {op, a, b, modulus}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a, req_b, req_modulus;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_error;
    logic                     eng_start;
    logic [WIDTH-1:0]         eng_a, eng_b, eng_modulus;
    logic [2:0]               eng_operation;
    logic [WIDTH-1:0]         eng_result;
    logic                     eng_done, eng_busy, eng_error;
    logic [IW-1:0]            grant_id;
    logic [1:0]               state_dbg;

    mod_arith_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_modulus(req_modulus), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_modulus(eng_modulus), .eng_operation(eng_operation),
        .eng_result(eng_result), .eng_done(eng_done), .eng_busy(eng_busy),
        .eng_error(eng_error), .grant_id(grant_id), .state_dbg(state_dbg)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [WIDTH-1:0] mod_fn(input logic [63:0] a, input logic [63:0] b,
                                                input logic [63:0] m, input logic [2:0] op);
        logic [63:0] r;
        case (op)
            3'b000:  r = (a + b) % m;
            3'b001:  r = ((a % m) + m - (b % m)) % m;
            default: r = (a * b) % m;
        endcase
        return WIDTH'(r);
    endfunction

    // ---------------- engine stub ----------------
    // mode 0: done after stub_lat (error for op[2]); 2: done+error together; 3: never completes
    int               stub_mode;
    int               stub_lat;
    logic             spur;
    int               s_cnt;
    logic             s_pend;
    logic [WIDTH-1:0] s_a, s_b, s_m;
    logic [2:0]       s_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done   <= 1'b0;
            eng_error  <= 1'b0;
            eng_result <= '0;
            s_pend     <= 1'b0;
            s_cnt      <= 0;
        end else begin
            eng_done  <= spur;
            eng_error <= 1'b0;
            if (eng_start) begin
                s_pend <= 1'b1;
                s_cnt  <= stub_lat;
                s_a    <= eng_a;
                s_b    <= eng_b;
                s_m    <= eng_modulus;
                s_op   <= eng_operation;
            end else if (s_pend) begin
                if (s_cnt <= 1) begin
                    if (stub_mode == 2) begin
                        s_pend     <= 1'b0;
                        eng_done   <= 1'b1;
                        eng_error  <= 1'b1;
                        eng_result <= 32'hdeadbeef;
                    end else if (stub_mode != 3) begin
                        s_pend <= 1'b0;
                        if (s_op[2]) begin
                            eng_error  <= 1'b1;
                            eng_result <= 32'hdeadbeef;
                        end else begin
                            eng_done   <= 1'b1;
                            eng_result <= mod_fn(64'(s_a), 64'(s_b), 64'(s_m), s_op);
                        end
                    end
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [QW-1:0] iss_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_acc = -10;
    int  last_done = -10;
    int  start_cyc = -10;
    int  rsp_cyc = -10;
    bit  expect_timeout = 1'b0;
    int  my_rr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] m, input logic [2:0] op);
        req_a[id*WIDTH +: WIDTH]       = a;
        req_b[id*WIDTH +: WIDTH]       = b;
        req_modulus[id*WIDTH +: WIDTH] = m;
        req_op[id*3 +: 3]              = op;
        req_valid[id]                  = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] m, input logic [2:0] op,
                            input logic err, input logic [WIDTH-1:0] res, input bit with_rsp);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        iss_q.push_back({op, a, b, m});
        if (with_rsp) exp_q.push_back({oh, err, res});
    endtask

    task automatic request(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] m, input logic [2:0] op,
                           input logic err, input logic [WIDTH-1:0] res, input bit with_rsp);
        set_req(id, a, b, m, op);
        push_exp(id, a, b, m, op, err, res, with_rsp);
    endtask

    // One clock: sample at negedge, retire accepted requests just after posedge.
    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        logic [EW-1:0]      e;
        logic [QW-1:0]      q;
        @(negedge clk);
        cyc++;
        acc = req_valid & req_ready;
        if (req_ready != '0) begin
            check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
            last_acc = cyc;
        end
        if (eng_start) begin
            start_cyc = cyc;
            check("start_latency", 64'(cyc), 64'(last_acc + 1));
            if (iss_q.size() == 0) begin
                check("start_unexpected", 64'(eng_start), 64'd0);
            end else begin
                q = iss_q.pop_front();
                check("eng_operation", 64'(eng_operation), 64'(q[QW-1 -: 3]));
                check("eng_a", 64'(eng_a), 64'(q[3*WIDTH-1 -: WIDTH]));
                check("eng_b", 64'(eng_b), 64'(q[2*WIDTH-1 -: WIDTH]));
                check("eng_modulus", 64'(eng_modulus), 64'(q[WIDTH-1:0]));
            end
        end
        if (rsp_valid != '0) begin
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e[EW-1 -: NUM_REQ]));
                check("rsp_error", 64'(rsp_error), 64'(e[WIDTH]));
                check("rsp_result", 64'(rsp_result), 64'(e[WIDTH-1:0]));
                if (!expect_timeout) check("rsp_latency", 64'(cyc), 64'(last_done + 1));
            end
        end
        if ((eng_done || eng_error) && !spur) last_done = cyc;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((req_valid != '0 || exp_q.size() != 0 || iss_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size() + iss_q.size()), 64'd0);
        exp_q.delete();
        iss_q.delete();
        req_valid = '0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        check({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
        check({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        check({tag, "_eng_a"}, 64'(eng_a), 64'd0);
        check({tag, "_eng_op"}, 64'(eng_operation), 64'd0);
        check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [WIDTH-1:0]   ra, rb, rm;
        logic [2:0]         rop;
        logic [NUM_REQ-1:0] mask;
        int                 g, last_g;

        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_modulus = '0; req_op = '0;
        eng_busy = 1'b0; spur = 1'b0; stub_mode = 0; stub_lat = 3;

        // Contention from reset: all three mul 3*4 mod 7 = 5, served 0,1,2.
        for (int i = 0; i < NUM_REQ; i++) request(i, 3, 4, 7, 3'b010, 1'b0, 5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain(100);

        // Only req1 raised while rr_ptr = 0: req0 idle, so req1 wins.
        request(1, 3, 4, 7, 3'b010, 1'b0, 5, 1'b1);
        drain(50);
        check("grant_id_req1", 64'(grant_id), 64'd1);

        // Random contention rounds, expected grant order from a round-robin model.
        my_rr = 2;
        for (int r = 0; r < 5; r++) begin
            mask = NUM_REQ'($urandom_range(1, 7));
            stub_lat = $urandom_range(1, 6);
            last_g = my_rr;
            for (int k = 0; k < NUM_REQ; k++) begin
                g = (my_rr + k) % NUM_REQ;
                if (mask[g]) begin
                    ra = $urandom; rb = $urandom; rm = $urandom_range(2, 1000);
                    rop = 3'($urandom_range(0, 2));
                    request(g, ra, rb, rm, rop, 1'b0, mod_fn(64'(ra), 64'(rb), 64'(rm), rop), 1'b1);
                    last_g = g;
                end
            end
            my_rr = (last_g + 1) % NUM_REQ;
            drain(200);
        end

        // Single add: 5+7 mod 11 = 1.
        stub_lat = 2;
        request(0, 5, 7, 11, 3'b000, 1'b0, 1, 1'b1);
        drain(50);

        // Error path: reserved opcode forwarded, engine errors, result zeroed.
        request(2, 9, 9, 13, 3'b100, 1'b1, 0, 1'b1);
        drain(50);
        check("error_hold_result", 64'(rsp_result), 64'd0);

        // Simultaneous done+error: error wins.
        stub_mode = 2;
        request(1, 2, 3, 5, 3'b000, 1'b1, 0, 1'b1);
        drain(50);
        stub_mode = 0;

        // Sub with result held after RESP: (4 - 9) mod 10 = 5.
        request(0, 4, 9, 10, 3'b001, 1'b0, 5, 1'b1);
        drain(50);
        repeat (3) tick();
        check("result_hold", 64'(rsp_result), 64'd5);

        // Engine busy blocks grants.
        eng_busy = 1'b1;
        request(2, 6, 6, 7, 3'b000, 1'b0, 5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_no_grant", 64'(req_ready), 64'd0);
        end
        eng_busy = 1'b0;
        drain(50);

        // Spurious done while idle must not produce a response.
        spur = 1'b1;
        repeat (5) tick();
        spur = 1'b0;
        repeat (2) tick();

        // Reset 20 cycles into WAIT: everything clears, no response follows.
        stub_mode = 3;
        request(0, 1, 1, 3, 3'b000, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10 && iss_q.size() != 0; i++) tick();
        check("abort_started", 64'(iss_q.size()), 64'd0);
        repeat (19) tick();
        req_valid = 3'b010;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        req_valid = '0;
        stub_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) tick();
        request(2, 10, 20, 7, 3'b000, 1'b0, 2, 1'b1);
        drain(50);

        // Engine that never completes.
        stub_mode = 3;
`ifdef MODARB_TIMEOUT_EN
        expect_timeout = 1'b1;
        request(1, 1, 2, 3, 3'b000, 1'b1, 0, 1'b1);
        drain(60);
        check("timeout_latency", 64'(rsp_cyc - start_cyc), 64'd17);
        expect_timeout = 1'b0;
`else
        request(1, 1, 2, 3, 3'b000, 1'b1, 0, 1'b0);
        repeat (40) tick();
        check("no_timeout_state", 64'(state_dbg), 64'd2);
        check("no_timeout_rsp", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
`endif
        stub_mode = 0;
        request(0, 3, 4, 7, 3'b010, 1'b0, 5, 1'b1);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
